// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: groups the signals between the fetch controller and its
// neighbours: the PC register, instruction memory and the decode stage.
// master = fetch controller view, slave = environment view.
interface ifetch_ctrl_if;
   logic [31:0] pc_in;
   logic        pc_ena;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fetch_err;

   modport master (
      input  pc_in, imem_ack, imem_rdata, instr_ready,
      output pc_ena, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err
   );

   modport slave (
      output pc_in, imem_ack, imem_rdata, instr_ready,
      input  pc_ena, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller. Latches the PC, runs a req/ack
// transaction to instruction memory, holds the fetched word until decode
// accepts it, then pulses pc_ena so the PC register loads the next PC.
// Optional feature macro: IFETCH_TIMEOUT_EN -- aborts a fetch that waits
// TIMEOUT_CYCLES cycles in REQ without ack and reports it as fetch_err.
module ifetch_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          rst,
   ifetch_ctrl_if.master bus
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("ifetch_ctrl: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADV  = 2'd1,
      REQ  = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic        fetch_err_q;
   logic        pc_aligned;
   logic        ack_in_req;
   logic        timeout_hit;

   assign pc_aligned = (bus.pc_in[1:0] == 2'b00);
   assign ack_in_req = (state_q == REQ) && bus.imem_ack;

`ifdef IFETCH_TIMEOUT_EN
   logic [15:0] to_cnt_q;

   // Wait-cycle counter: cleared while in ADV (i.e. on entry to REQ), counts REQ cycles without ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (state_q == ADV) begin
         to_cnt_q <= '0;
      end else if ((state_q == REQ) && !bus.imem_ack) begin
         to_cnt_q <= to_cnt_q + 16'd1;
      end
   end

   // The limit is reached in the cycle where this REQ cycle would be the
   // TIMEOUT_CYCLES-th one without ack; an ack in that cycle still wins.
   assign timeout_hit = (state_q == REQ) && !bus.imem_ack &&
                        (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned
      // (which would infer a latch).
      state_d = state_q;
      unique case (state_q)
         IDLE: state_d = ADV;
         ADV:  state_d = pc_aligned ? REQ : HOLD;
         REQ:  if (bus.imem_ack || timeout_hit) state_d = HOLD;
         HOLD: if (bus.instr_ready) state_d = ADV;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state; pc_ena is the only one that also
   // looks at an input, so decode's accept loads the PC on the same edge.
   always_comb begin
      bus.imem_req    = (state_q == REQ);
      bus.instr_valid = (state_q == HOLD);
      bus.pc_ena      = (state_q == HOLD) && bus.instr_ready;
   end

   // Fetch datapath: address latch and the held instruction/result fields.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: these are a handful of output-visible flops, not a memory, so
      // all of them reset to give defined outputs straight out of reset.
      if (rst) begin
         addr_q      <= '0;
         instr_q     <= '0;
         instr_pc_q  <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         if (state_q == ADV) begin
            addr_q <= bus.pc_in;
            if (!pc_aligned) begin
               instr_q     <= '0;
               instr_pc_q  <= bus.pc_in;
               fetch_err_q <= 1'b1;
            end
         end
         if (ack_in_req) begin
            instr_q     <= bus.imem_rdata;
            instr_pc_q  <= addr_q;
            fetch_err_q <= 1'b0;
         end else if (timeout_hit) begin
            instr_q     <= '0;
            instr_pc_q  <= addr_q;
            fetch_err_q <= 1'b1;
         end
      end
   end

   assign bus.imem_addr = addr_q;
   assign bus.instr     = instr_q;
   assign bus.instr_pc  = instr_pc_q;
   assign bus.fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: table-driven bench for ifetch_ctrl. Each vector is one
// fetch (PC, memory word, wait cycles, decode stall); the expected result is
// pushed to a scoreboard when the fetch starts and popped when pc_ena shows
// decode accepted it. Build with +define+IFETCH_TIMEOUT_EN to add the
// timeout vector.
module tb_ifetch_ctrl;

   localparam int TO_CYC = 8;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      int          wait_cyc;   // ack after this many wait cycles; <0 = never ack
      int          ready_dly;  // cycles decode stalls in HOLD
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   logic pc_ena_prev;
   exp_t sb_q[$];
   vec_t vecs[$];

   ifetch_ctrl_if bus ();

   ifetch_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pc_ena must never be high in two consecutive cycles.
   always @(negedge clk) begin
      if (bus.pc_ena === 1'b1) check("pc_ena_not_back_to_back", {31'b0, pc_ena_prev}, 32'd0);
      pc_ena_prev = bus.pc_ena;
   end

   task automatic check_idle();
      check("idle_req", {31'b0, bus.imem_req}, 32'd0);
      check("idle_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("idle_pc_ena", {31'b0, bus.pc_ena}, 32'd0);
      check("idle_err", {31'b0, bus.fetch_err}, 32'd0);
      check("idle_addr", bus.imem_addr, 32'd0);
      check("idle_instr", bus.instr, 32'd0);
      check("idle_instr_pc", bus.instr_pc, 32'd0);
   endtask

   // Entered in the ADV slot with pc_in already driven; returns in the next ADV slot.
   task automatic run_vec(input vec_t v);
      exp_t e;
      logic err;
      int   n;
      err     = (v.pc[1:0] != 2'b00) || (v.wait_cyc < 0);
      e.instr = err ? 32'd0 : v.rdata;
      e.pc    = v.pc;
      e.err   = err;
      check("adv_req", {31'b0, bus.imem_req}, 32'd0);
      check("adv_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("adv_pc_ena", {31'b0, bus.pc_ena}, 32'd0);
      sb_q.push_back(e);
      tick();
      if (v.pc[1:0] != 2'b00) begin
         check("misaligned_no_req", {31'b0, bus.imem_req}, 32'd0);
      end else if (v.wait_cyc < 0) begin
         n = 0;
         while (bus.imem_req === 1'b1 && n < 4 * TO_CYC + 8) begin
            check("timeout_addr", bus.imem_addr, v.pc);
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            tick();
            n++;
         end
         check("timeout_req_cycles", n, TO_CYC);
      end else begin
         for (int i = 0; i <= v.wait_cyc; i++) begin
            check("req", {31'b0, bus.imem_req}, 32'd1);
            check("req_addr", bus.imem_addr, v.pc);
            check("req_valid", {31'b0, bus.instr_valid}, 32'd0);
            bus.imem_ack   = (i == v.wait_cyc);
            bus.imem_rdata = (i == v.wait_cyc) ? v.rdata : $urandom;
            #1;
            check("req_pc_ena", {31'b0, bus.pc_ena}, 32'd0);
            tick();
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
         end
      end
      // HOLD: stall decode, throw stray acks at the block, fields must not move.
      check("hold_req", {31'b0, bus.imem_req}, 32'd0);
      bus.instr_ready = 1'b0;
      for (int i = 0; i < v.ready_dly; i++) begin
         bus.imem_ack   = 1'b1;
         bus.imem_rdata = $urandom;
         #1;
         check("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
         check("stall_pc_ena", {31'b0, bus.pc_ena}, 32'd0);
         check("stall_instr", bus.instr, e.instr);
         check("stall_instr_pc", bus.instr_pc, e.pc);
         check("stall_err", {31'b0, bus.fetch_err}, {31'b0, e.err});
         tick();
      end
      bus.imem_ack    = 1'b0;
      bus.instr_ready = 1'b1;
      #1;
      check("accept_valid", {31'b0, bus.instr_valid}, 32'd1);
      check("accept_pc_ena", {31'b0, bus.pc_ena}, 32'd1);
      if (sb_q.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check("sb_instr", bus.instr, e.instr);
         check("sb_instr_pc", bus.instr_pc, e.pc);
         check("sb_err", {31'b0, bus.fetch_err}, {31'b0, e.err});
      end
      tick();
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      pc_ena_prev = 1'b0;

      vecs.push_back('{32'h0040_0000, 32'h0000_0013, 0, 0});
      vecs.push_back('{32'h0040_0004, 32'hDEAD_BEEF, 4, 0});
      vecs.push_back('{32'h0040_0008, 32'h1234_5678, 0, 10});
      vecs.push_back('{32'h0040_0002, 32'hFFFF_FFFF, 0, 0});
      vecs.push_back('{32'h0040_000C, 32'hCAFE_F00D, 2, 3});
      vecs.push_back('{32'h0040_0001, 32'h5555_AAAA, 0, 2});
      vecs.push_back('{32'hFFFF_FFFC, 32'hA5A5_A5A5, 1, 1});
      vecs.push_back('{32'h0040_0010, 32'h0F0F_0F0F, TO_CYC - 1, 0});
`ifdef IFETCH_TIMEOUT_EN
      vecs.push_back('{32'h0040_0040, 32'h7777_7777, -1, 2});
`endif

      rst             = 1'b1;
      bus.pc_in       = vecs[0].pc;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 32'd0;
      bus.instr_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle();
      rst = 1'b0;
      check_idle();
      tick();

      foreach (vecs[i]) begin
         bus.pc_in = vecs[i].pc;
         run_vec(vecs[i]);
      end

      // Reset in the middle of a waiting fetch, then restart from the new PC.
      bus.pc_in = 32'h0040_0100;
      tick();
      check("pre_rst_req", {31'b0, bus.imem_req}, 32'd1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_req", {31'b0, bus.imem_req}, 32'd0);
      check("rst_async_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("rst_async_pc_ena", {31'b0, bus.pc_ena}, 32'd0);
      tick();
      bus.pc_in = 32'h0040_0200;
      rst       = 1'b0;
      check_idle();
      tick();
      run_vec('{32'h0040_0200, 32'h0BAD_C0DE, 0, 0});

      check("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller between the program-counter register and instruction memory. Latches the current PC, runs a req/ack transaction to instruction memory, holds the fetched word for the decode stage until accepted, then pulses the PC register's enable so the next PC is loaded. It turns the single-cycle datapath into one that tolerates wait-stated instruction memory.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in REQ without ack before abort. Range 1..65535. Used only with IFETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc_in  in  32  current PC from the PC register output
- pc_ena  out  1  enable to the PC register; loads next PC at the following rising edge
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch byte address, stable while imem_req=1
- imem_ack  in  1  memory completion; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc/fetch_err valid
- instr_ready  in  1  decode stage accepts the held instruction
- instr  out  32  fetched instruction (0 on error)
- instr_pc  out  32  address the instruction came from
- fetch_err  out  1  misaligned PC (or timeout), qualified by instr_valid

## Operation
- States: IDLE, ADV, REQ, HOLD. 2-bit state register; all registers reset asynchronously.
- IDLE: entered only by reset. Always goes to ADV next cycle.
- ADV: latch addr_q <= pc_in.
  - If pc_in[1:0]==0: go to REQ.
  - Otherwise: go straight to HOLD with fetch_err=1 and instr=0. No memory request is issued.
- REQ: imem_req=1, imem_addr=addr_q.
  - imem_ack sampled only in REQ; ack in any other state is ignored.
  - On ack: instr <= imem_rdata, instr_pc <= addr_q, fetch_err <= 0; go to HOLD.
- HOLD: instr_valid=1; outputs frozen.
  - pc_ena = (state==HOLD) && instr_ready. This is combinational and the only path that asserts pc_ena.
  - On accept: go to ADV. The PC register updates on the same edge, so ADV samples the new PC.
- A fetch error does not stall. The consumer accepts it like a normal instruction and pc_ena pulses as usual.
- imem_req, instr_valid and imem_addr are decoded from registered state only.

## Timing
- Reset values:
  - state=IDLE
  - pc_ena=0, imem_req=0, instr_valid=0, fetch_err=0
  - imem_addr=0, instr=0, instr_pc=0
- Reset asserted mid-transaction drops imem_req immediately, with no completion. Instruction memory must tolerate an abandoned request.
- Zero-wait memory (ack in the first REQ cycle):
  - ack to instr_valid latency: 1 cycle.
  - Minimum 3 cycles per instruction (ADV, REQ, HOLD), with instr_ready held high.
- N wait cycles add N cycles in REQ.
- After reset release: first imem_req at cycle 2 (IDLE, ADV, REQ).
- pc_ena is high for exactly one cycle per accepted instruction and never in consecutive cycles.
- instr_ready while not in HOLD has no effect.

## Configuration
- IFETCH_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack: imem_req drops, the block goes to HOLD with fetch_err=1, instr=0, instr_pc=addr_q.
  - An ack in the same cycle as the limit wins.
- IFETCH_TIMEOUT_EN undefined:
  - No counter; REQ waits indefinitely.
  - fetch_err is raised only for a misaligned PC.
  - TIMEOUT_CYCLES is ignored.

## Test plan
- Reset, pc_in=0x00400000, ack in the first REQ cycle, instr_ready=1 → imem_req at cycle 2 with addr 0x00400000; instr_valid cycle 3 with instr=rdata; pc_ena one cycle in cycle 3.
- ack delayed 4 cycles → imem_addr stable for 5 REQ cycles; exactly one capture; no pc_ena before instr_ready.
- instr_ready held low 10 cycles in HOLD → instr/instr_pc unchanged, pc_ena=0 throughout; single pc_ena pulse on the first ready cycle.
- pc_in=0x00400002 → no imem_req; instr_valid with fetch_err=1, instr=0, instr_pc=0x00400002.
- rst pulsed while imem_req=1 → imem_req, instr_valid and pc_ena go 0 asynchronously; the fetch restarts from pc_in after release.
- IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never given → imem_req high for exactly 8 cycles, then fetch_err=1 with instr_valid.
